// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding, one-hot
// grant codes and the round-robin pointer update rule.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_IF   = 2'b01;
    localparam logic [1:0] GNT_DM   = 2'b10;

    // Pointer moves to the loser: 1 means the data port wins the next tie.
    function automatic logic next_ptr(input logic [1:0] gnt);
        return gnt[0];
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin picker (bit 0 = fetch, bit 1 = data).
// The tie-break pointer resets data-first and advances when a pick is taken.
module rr_arb2
    import mem_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic       ptr_r;
    logic [1:0] gnt_s;

    // Combinational pick: a lone requester always wins, ties follow the pointer.
    always_comb begin
        gnt_s = GNT_NONE;
        case (req)
            2'b01:   gnt_s = GNT_IF;
            2'b10:   gnt_s = GNT_DM;
            2'b11:   gnt_s = ptr_r ? GNT_DM : GNT_IF;
            default: gnt_s = GNT_NONE;
        endcase
    end

    // Tie-break pointer register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r <= 1'b1;
        end else if (advance && (gnt_s != GNT_NONE)) begin
            ptr_r <= next_ptr(gnt_s);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign gnt = gnt_s;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and data ports, one
// transaction in flight. Optional watchdog abort enabled by MEM_ARB_WDT_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              err
);

    arb_state_e        state_r;
    logic [1:0]        grant_r;
    logic [1:0]        pick_s;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] dm_rdata_r;
    logic              if_ack_r;
    logic              dm_ack_r;
    logic              busy_r;

    // A watchdog limit below one cycle is meaningless; nothing is built for it.
    if (TIMEOUT < 1) begin : g_timeout_out_of_range
    end

`ifdef MEM_ARB_WDT_EN
    localparam int WDT_W = $clog2(TIMEOUT + 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(TIMEOUT - 1);

    logic [WDT_W-1:0] wdt_cnt_r;
    logic             err_r;
`endif

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset   (reset),
        .req     ({dm_req, if_req}),
        .advance (state_r == ST_IDLE),
        .gnt     (pick_s)
    );

    // Transaction FSM with all port-facing registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            grant_r     <= GNT_NONE;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            if_rdata_r  <= {DATA_W{1'b0}};
            dm_rdata_r  <= {DATA_W{1'b0}};
            if_ack_r    <= 1'b0;
            dm_ack_r    <= 1'b0;
            busy_r      <= 1'b0;
`ifdef MEM_ARB_WDT_EN
            wdt_cnt_r   <= {WDT_W{1'b0}};
            err_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_s != GNT_NONE) begin
                        state_r     <= ST_BUSY;
                        grant_r     <= pick_s;
                        busy_r      <= 1'b1;
                        mem_req_r   <= 1'b1;
                        // Fetch never writes, so only the data port can raise mem_we.
                        mem_we_r    <= pick_s[1] & dm_we;
                        mem_addr_r  <= pick_s[1] ? dm_addr : if_addr;
                        mem_wdata_r <= pick_s[1] ? dm_wdata : {DATA_W{1'b0}};
`ifdef MEM_ARB_WDT_EN
                        wdt_cnt_r   <= {WDT_W{1'b0}};
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (mem_ready) begin
                        state_r   <= ST_ACK;
                        mem_req_r <= 1'b0;
                        if (grant_r[1]) begin
                            dm_ack_r <= 1'b1;
                            if (!mem_we_r) begin
                                dm_rdata_r <= mem_rdata;
                            end
                        end else begin
                            if_ack_r   <= 1'b1;
                            if_rdata_r <= mem_rdata;
                        end
                    end
`ifdef MEM_ARB_WDT_EN
                    else if (wdt_cnt_r == WDT_LAST) begin
                        // Abort: owner gets its ack with err, read data untouched.
                        state_r   <= ST_ACK;
                        mem_req_r <= 1'b0;
                        dm_ack_r  <= grant_r[1];
                        if_ack_r  <= grant_r[0];
                        err_r     <= 1'b1;
                    end else begin
                        wdt_cnt_r <= wdt_cnt_r + WDT_W'(1);
                    end
`else
                    else begin
                        state_r <= ST_BUSY;
                    end
`endif
                end
                ST_ACK: begin
                    state_r  <= ST_IDLE;
                    grant_r  <= GNT_NONE;
                    busy_r   <= 1'b0;
                    if_ack_r <= 1'b0;
                    dm_ack_r <= 1'b0;
`ifdef MEM_ARB_WDT_EN
                    err_r    <= 1'b0;
`endif
                end
                default: begin
                    state_r   <= ST_IDLE;
                    grant_r   <= GNT_NONE;
                    busy_r    <= 1'b0;
                    mem_req_r <= 1'b0;
                    if_ack_r  <= 1'b0;
                    dm_ack_r  <= 1'b0;
                end
            endcase
        end
    end

    assign if_rdata  = if_rdata_r;
    assign if_ack    = if_ack_r;
    assign dm_rdata  = dm_rdata_r;
    assign dm_ack    = dm_ack_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign grant     = grant_r;
    assign busy      = busy_r;
`ifdef MEM_ARB_WDT_EN
    assign err       = err_r;
`else
    assign err       = 1'b0;
`endif

endmodule
